md_sched: RTL and testbench

Multiply/divide scheduler for the E stage of the pipelined MIPS core.
- Accepts mult/multu/div/divu/mthi/mtlo/mfhi/mflo from the E-stage control decode.
- Sequences a fixed-latency multi-cycle operation, owns the HI/LO registers and commits them at completion.
- Drives the busy/start signals the stall unit uses to hold HI/LO-dependent instructions in D.

---
 rtl/md_sched_if.sv | 26 ++
 rtl/md_sched.sv | 120 ++++++++++++
 tb/tb_md_sched.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/md_sched_if.sv
// Bundle between the E-stage decode/stall unit and the multiply/divide scheduler.
// Valid/ready: an op is taken only when valid_e=1 and start=1 in the same cycle; busy/stall_req hold off further md ops.
interface md_sched_if;
  logic [3:0]  op;
  logic        valid_e;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        d_is_md;
  logic        start;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rd_data;
  logic        dbg_state;

  modport slave (
    input  op, valid_e, rs_val, rt_val, d_is_md,
    output start, busy, stall_req, hi, lo, rd_data, dbg_state
  );

  modport master (
    output op, valid_e, rs_val, rt_val, d_is_md,
    input  start, busy, stall_req, hi, lo, rd_data, dbg_state
  );
endinterface

// File: rtl/md_sched.sv
// Multiply/divide scheduler: fixed-latency mult/div sequencing, HI/LO ownership
// and the busy/start/stall signals used to hold HI/LO consumers in D.
module md_sched #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  md_sched_if.slave   md
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] p_hi_q, p_hi_d, p_lo_q, p_lo_d;
  logic        p_ok_q, p_ok_d;

  logic        start;
  logic        is_div;
  logic        rt_zero;
  logic        div_ovf;
  logic signed [63:0] a_s, b_s, prod_s;
  logic [63:0] a_u, b_u, prod_u;
  logic [31:0] divu_den;
  logic signed [31:0] div_num, div_den, quo_s, rem_s;
  logic [31:0] quo_u, rem_u;

  assign is_div  = (md.op == 4'd3) || (md.op == 4'd4);
  assign rt_zero = (md.rt_val == 32'd0);
  assign start   = reset && md.valid_e && (md.op >= 4'd1) && (md.op <= 4'd4) && (state_q == IDLE);

  // Divide by zero and the signed overflow case are steered onto a divisor of 1:
  // zero is discarded via p_ok, and 0x80000000 / 1 is exactly the required overflow result.
  assign div_ovf  = (md.rs_val == 32'h8000_0000) && (md.rt_val == 32'hFFFF_FFFF);
  assign div_num  = $signed(md.rs_val);
  assign div_den  = (rt_zero || div_ovf) ? 32'sd1 : $signed(md.rt_val);
  assign divu_den = rt_zero ? 32'd1 : md.rt_val;
  assign quo_s    = div_num / div_den;
  assign rem_s    = div_num % div_den;
  assign quo_u    = md.rs_val / divu_den;
  assign rem_u    = md.rs_val % divu_den;

  assign a_s    = {{32{md.rs_val[31]}}, md.rs_val};
  assign b_s    = {{32{md.rt_val[31]}}, md.rt_val};
  assign prod_s = a_s * b_s;
  assign a_u    = {32'd0, md.rs_val};
  assign b_u    = {32'd0, md.rt_val};
  assign prod_u = a_u * b_u;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    p_hi_d  = p_hi_q;
    p_lo_d  = p_lo_q;
    p_ok_d  = p_ok_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
          p_ok_d  = !(is_div && rt_zero);
          case (md.op)
            4'd1:    begin p_hi_d = prod_s[63:32];  p_lo_d = prod_s[31:0]; end
            4'd2:    begin p_hi_d = prod_u[63:32];  p_lo_d = prod_u[31:0]; end
            4'd3:    begin p_hi_d = 32'(rem_s);     p_lo_d = 32'(quo_s);   end
            default: begin p_hi_d = rem_u;          p_lo_d = quo_u;        end
          endcase
        end else if (md.valid_e && (md.op == 4'd5)) begin
          hi_d = md.rs_val;
        end else if (md.valid_e && (md.op == 4'd6)) begin
          lo_d = md.rs_val;
        end
      end
      RUN: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = IDLE;
          if (p_ok_q) begin
            hi_d = p_hi_q;
            lo_d = p_lo_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      p_hi_q  <= 32'd0;
      p_lo_q  <= 32'd0;
      p_ok_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      p_hi_q  <= p_hi_d;
      p_lo_q  <= p_lo_d;
      p_ok_q  <= p_ok_d;
    end
  end

  assign md.start     = start;
  assign md.busy      = (state_q == RUN);
  assign md.stall_req = md.d_is_md && (start || (state_q == RUN));
  assign md.hi        = hi_q;
  assign md.lo        = lo_q;
  assign md.rd_data   = (md.op == 4'd7) ? hi_q : ((md.op == 4'd8) ? lo_q : 32'd0);
  assign md.dbg_state = (state_q == RUN);

endmodule

// File: tb/tb_md_sched.sv
// Randomized bench for md_sched: a driver issues ops, a monitor checks every
// commit (latency and HI/LO) against results queued by a reference model.
module tb_md_sched;
  localparam int MC = 5;
  localparam int DC = 10;

  logic clk;
  logic reset;
  md_sched_if mif ();

  md_sched #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (mif.slave)
  );

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_q[$];
  int          lat_q[$];
  logic [31:0] m_hi, m_lo;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on magnitudes and signs.
  function automatic logic [63:0] ref_res(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    longint unsigned ma, mb, q, r, ua, ub, p;
    ref_res = 64'd0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    case (o)
      4'd1: ref_res = 64'(sa * sb);
      4'd2: begin p = ua * ub; ref_res = p; end
      4'd3: begin
        ma = (sa < 0) ? longint'(-sa) : longint'(sa);
        mb = (sb < 0) ? longint'(-sb) : longint'(sb);
        q = ma / mb;
        r = ma % mb;
        if ((sa < 0) != (sb < 0)) q = -q;
        if (sa < 0) r = -r;
        ref_res = {r[31:0], q[31:0]};
      end
      4'd4: begin q = ua / ub; r = ua % ub; ref_res = {r[31:0], q[31:0]}; end
      default: ref_res = 64'd0;
    endcase
  endfunction

  // monitor: counts busy cycles and checks each commit
  initial begin
    int run_cnt;
    logic prev_busy;
    logic [63:0] e;
    int l;
    run_cnt = 0;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_busy = 1'b0;
        run_cnt = 0;
      end else begin
        if (mif.busy) run_cnt++;
        else if (prev_busy) begin
          if (exp_q.size() == 0) check("commit_unexpected", 64'd1, 64'd0);
          else begin
            e = exp_q.pop_front();
            l = lat_q.pop_front();
            check("busy_cycles", 64'(run_cnt), 64'(l));
            check("commit_hilo", {mif.hi, mif.lo}, e);
          end
          run_cnt = 0;
        end
        prev_busy = mif.busy;
      end
    end
  end

  // driver: present one op for one cycle, then wait for any long op to finish
  task automatic do_op(input logic [3:0] o, input logic v, input logic [31:0] a, input logic [31:0] b, input logic dmd);
    logic exp_start, is_div, ok, done;
    logic [63:0] res, old;
    int n, stall_cnt;
    @(posedge clk); #1;
    mif.op = o; mif.valid_e = v; mif.rs_val = a; mif.rt_val = b; mif.d_is_md = dmd;
    #1;
    exp_start = v && (o >= 4'd1) && (o <= 4'd4);
    is_div = (o == 4'd3) || (o == 4'd4);
    check("start", 64'(mif.start), 64'(exp_start));
    check("stall_issue", 64'(mif.stall_req), 64'(dmd && exp_start));
    check("rd_data", 64'(mif.rd_data), (o == 4'd7) ? 64'(m_hi) : ((o == 4'd8) ? 64'(m_lo) : 64'd0));
    old = {m_hi, m_lo};
    stall_cnt = (mif.stall_req === 1'b1) ? 1 : 0;
    n = is_div ? DC : MC;
    if (exp_start) begin
      ok = !(is_div && (b == 32'd0));
      res = ok ? ref_res(o, a, b) : old;
      exp_q.push_back(res);
      lat_q.push_back(n);
      {m_hi, m_lo} = res;
    end else if (v && o == 4'd5) m_hi = a;
    else if (v && o == 4'd6) m_lo = a;
    @(posedge clk); #1;
    mif.op = 4'd0; mif.valid_e = 1'b0;
    if (!exp_start) begin
      check("hilo_short", {mif.hi, mif.lo}, {m_hi, m_lo});
      check("busy_short", 64'(mif.busy), 64'd0);
    end else begin
      done = 1'b0;
      for (int k = 0; k < 40 && !done; k++) begin
        @(negedge clk);
        if (mif.busy) begin
          check("start_in_run", 64'(mif.start), 64'd0);
          check("stall_busy", 64'(mif.stall_req), 64'(dmd));
          check("hilo_hold", {mif.hi, mif.lo}, old);
          if (mif.stall_req === 1'b1) stall_cnt++;
          mif.op = 4'($urandom_range(1, 6));
          mif.valid_e = 1'b1;
          mif.rs_val = $urandom;
          mif.rt_val = $urandom;
        end else begin
          done = 1'b1;
          mif.op = 4'd0;
          mif.valid_e = 1'b0;
        end
      end
      if (!done) check("busy_timeout", 64'd1, 64'd0);
      if (dmd) check("stall_cycles", 64'(stall_cnt), 64'(n + 1));
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: pick = 32'd0;
      1: pick = 32'h8000_0000;
      2: pick = 32'hFFFF_FFFF;
      3: pick = 32'($urandom_range(0, 20));
      default: pick = $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b0;
    mif.op = 4'd0; mif.valid_e = 1'b0; mif.rs_val = 32'd0; mif.rt_val = 32'd0; mif.d_is_md = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    #12;
    check("rst_hilo", {mif.hi, mif.lo}, 64'd0);
    check("rst_busy", 64'(mif.busy), 64'd0);
    check("rst_start", 64'(mif.start), 64'd0);
    check("rst_stall", 64'(mif.stall_req), 64'd0);
    @(negedge clk); reset = 1'b1;

    // directed cases
    do_op(4'd1, 1'b1, 32'hFFFF_FFFF, 32'h2, 1'b0);
    check("mult_dir", {mif.hi, mif.lo}, 64'hFFFF_FFFF_FFFF_FFFE);
    do_op(4'd2, 1'b1, 32'hFFFF_FFFF, 32'h2, 1'b1);
    check("multu_dir", {mif.hi, mif.lo}, 64'h0000_0001_FFFF_FFFE);
    do_op(4'd3, 1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0);
    check("div_dir", {mif.hi, mif.lo}, 64'h0000_0001_FFFF_FFFD);
    do_op(4'd3, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("div_ovf", {mif.hi, mif.lo}, 64'h0000_0000_8000_0000);
    do_op(4'd5, 1'b1, 32'h11, 32'd0, 1'b1);
    do_op(4'd6, 1'b1, 32'h22, 32'd0, 1'b1);
    do_op(4'd4, 1'b1, 32'h1234, 32'd0, 1'b1);
    check("divu_zero", {mif.hi, mif.lo}, 64'h0000_0011_0000_0022);

    // reset in the middle of a mult
    @(posedge clk); #1;
    mif.op = 4'd1; mif.valid_e = 1'b1; mif.rs_val = 32'd3; mif.rt_val = 32'd4; mif.d_is_md = 1'b0;
    @(posedge clk); #1;
    mif.op = 4'd0; mif.valid_e = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    exp_q.delete(); lat_q.delete();
    m_hi = 32'd0; m_lo = 32'd0;
    #1;
    check("abort_busy", 64'(mif.busy), 64'd0);
    check("abort_hilo", {mif.hi, mif.lo}, 64'd0);
    @(negedge clk); reset = 1'b1;
    do_op(4'd5, 1'b1, 32'hABCD, 32'd0, 1'b0);
    check("mthi_after_rst", 64'(mif.hi), 64'hABCD);
    do_op(4'd7, 1'b1, 32'd0, 32'd0, 1'b0);

    // random traffic
    for (int i = 0; i < 150; i++)
      do_op(4'($urandom_range(0, 15)), ($urandom_range(0, 5) != 0), pick(), pick(), 1'($urandom_range(0, 1)));

    repeat (3) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
